// File: rtl/fetch_instr_buffer.sv
// Single-lane fetch request/retry stage with an in-order {pc, instr} output FIFO.
// Define FETCH_BUF_STATS_EN to add saturating probe_cnt/miss_cnt outputs.
`ifndef LEN_WORD
`define LEN_WORD 32
`endif
`ifndef LEN_INST
`define LEN_INST 32
`endif

module fetch_instr_buffer #(
   parameter int unsigned LEN_WORD  = `LEN_WORD,
   parameter int unsigned LEN_INST  = `LEN_INST,
   parameter int unsigned LOG_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [LEN_WORD-1:0] req_pc,
   input  logic                flush,
   output logic                fetch_order,
   output logic [LEN_WORD-1:0] fetch_pc,
   input  logic                fetch_done,
   input  logic [LEN_INST-1:0] fetch_instr,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LEN_WORD-1:0] out_pc,
   output logic [LEN_INST-1:0] out_instr
`ifdef FETCH_BUF_STATS_EN
   ,
   output logic [31:0]         probe_cnt,
   output logic [31:0]         miss_cnt
`endif
);

   localparam int unsigned DEPTH = 2**LOG_DEPTH;

   typedef enum logic [1:0] {IDLE, LOOKUP, MISS} state_t;

   state_t               state_q, state_d;
   logic [LEN_WORD-1:0]  pend_pc_q;
   logic [LOG_DEPTH-1:0] rd_q, wr_q;
   logic [LOG_DEPTH:0]   count_q;
   logic [LEN_WORD-1:0]  pc_mem    [DEPTH];
   logic [LEN_INST-1:0]  instr_mem [DEPTH];
   logic                 full, hit, accept, pop;

   // count never exceeds DEPTH, so its MSB alone marks a full FIFO
   assign full        = count_q[LOG_DEPTH];
   assign fetch_order = (state_q != IDLE) && !full;
   assign fetch_pc    = pend_pc_q;
   assign hit         = fetch_order && fetch_done;
   assign req_ready   = !flush && ((state_q == IDLE) || hit);
   assign accept      = req_valid && req_ready;
   assign out_valid   = (count_q != '0);
   assign pop         = out_valid && out_ready;
   assign out_pc      = pc_mem[rd_q];
   assign out_instr   = instr_mem[rd_q];

   // accept implies IDLE or hit, so it takes precedence over the hit->IDLE exit
   always_comb begin
      state_d = state_q;
      if (flush)
         state_d = IDLE;
      else if (accept)
         state_d = LOOKUP;
      else if (hit)
         state_d = IDLE;
      else if (fetch_order)
         state_d = MISS;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         pend_pc_q <= '0;
         rd_q      <= '0;
         wr_q      <= '0;
         count_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept)
            pend_pc_q <= req_pc;
         if (flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
         end else begin
            if (hit)
               wr_q <= wr_q + LOG_DEPTH'(1);
            if (pop)
               rd_q <= rd_q + LOG_DEPTH'(1);
            if (hit && !pop)
               count_q <= count_q + (LOG_DEPTH+1)'(1);
            else if (!hit && pop)
               count_q <= count_q - (LOG_DEPTH+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_mem    <= '{default: '0};
         instr_mem <= '{default: '0};
      end else if (hit && !flush) begin
         pc_mem[wr_q]    <= pend_pc_q;
         instr_mem[wr_q] <= fetch_instr;
      end
   end

`ifdef FETCH_BUF_STATS_EN
   // counters survive flush; only reset clears them
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         probe_cnt <= '0;
         miss_cnt  <= '0;
      end else begin
         if (fetch_order && (probe_cnt != '1))
            probe_cnt <= probe_cnt + 32'd1;
         if (fetch_order && !fetch_done && (miss_cnt != '1))
            miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_instr_buffer.sv
// Directed bench for fetch_instr_buffer: hit, miss/retry, full, stream, flush, async reset.
// Stats checks are active when FETCH_BUF_STATS_EN is defined.
module tb_fetch_instr_buffer;

   localparam int unsigned LW = 32;
   localparam int unsigned LI = 32;

   logic          clk = 1'b0;
   logic          rstn;
   logic          req_valid, req_ready, flush;
   logic [LW-1:0] req_pc, fetch_pc, out_pc;
   logic          fetch_order, fetch_done, out_valid, out_ready;
   logic [LI-1:0] fetch_instr, out_instr;
`ifdef FETCH_BUF_STATS_EN
   logic [31:0]   probe_cnt, miss_cnt;
`endif

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   fetch_instr_buffer #(.LEN_WORD(LW), .LEN_INST(LI), .LOG_DEPTH(2)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
      .flush(flush),
      .fetch_order(fetch_order), .fetch_pc(fetch_pc),
      .fetch_done(fetch_done), .fetch_instr(fetch_instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr)
`ifdef FETCH_BUF_STATS_EN
      , .probe_cnt(probe_cnt), .miss_cnt(miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic stats_chk(input string tag, input logic [31:0] p, input logic [31:0] m);
`ifdef FETCH_BUF_STATS_EN
      chk({tag, "_probe"}, probe_cnt, p);
      chk({tag, "_miss"}, miss_cnt, m);
`else
      if (tag.len() == 0) $display("[TB] note: %0h %0h", p, m);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_outv"}, out_valid, 1'b0);
      chk({tag, "_order"}, fetch_order, 1'b0);
      chk({tag, "_fpc"}, fetch_pc, '0);
      chk({tag, "_rdy"}, req_ready, 1'b1);
      chk({tag, "_opc"}, out_pc, '0);
      chk({tag, "_oinstr"}, out_instr, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0; req_valid = 1'b0; req_pc = '0; flush = 1'b0;
      fetch_done = 1'b0; fetch_instr = '0; out_ready = 1'b0;
      #2;
      chk_reset_vals("rst");
      stats_chk("rst", 32'd0, 32'd0);
      #10 rstn = 1'b1;
      tick();

      // hit on first probe
      req_valid = 1'b1; req_pc = 32'h100; fetch_done = 1'b1; fetch_instr = 32'hDEAD_BEEF;
      #1;
      chk("s1_req_ready", req_ready, 1'b1);
      chk("s1_order_idle", fetch_order, 1'b0);
      tick();
      req_valid = 1'b0;
      #1;
      chk("s1_order", fetch_order, 1'b1);
      chk("s1_fpc", fetch_pc, 32'h100);
      chk("s1_outv_early", out_valid, 1'b0);
      tick();
      fetch_done = 1'b0; fetch_instr = 'x;
      #1;
      chk("s1_outv", out_valid, 1'b1);
      chk("s1_opc", out_pc, 32'h100);
      chk("s1_oinstr", out_instr, 32'hDEAD_BEEF);
      chk("s1_idle", fetch_order, 1'b0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      chk("s1_popped", out_valid, 1'b0);

      // three misses then a hit
      req_valid = 1'b1; req_pc = 32'h100; fetch_done = 1'b0;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("s2_miss_order", fetch_order, 1'b1);
         chk("s2_miss_fpc", fetch_pc, 32'h100);
         chk("s2_miss_rdy", req_ready, 1'b0);
         tick();
      end
      fetch_done = 1'b1; fetch_instr = 32'h1111_1111;
      #1;
      chk("s2_hit_fpc", fetch_pc, 32'h100);
      chk("s2_hit_order", fetch_order, 1'b1);
      chk("s2_hit_rdy", req_ready, 1'b1);
      tick();
      fetch_done = 1'b0; fetch_instr = 'x;
      #1;
      chk("s2_outv", out_valid, 1'b1);
      chk("s2_opc", out_pc, 32'h100);
      chk("s2_oinstr", out_instr, 32'h1111_1111);
      chk("s2_idle", fetch_order, 1'b0);
      stats_chk("s2", 32'd5, 32'd3);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // fill the FIFO with a fifth request pending
      fetch_done = 1'b1;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1;
         req_pc = 32'h200 + 32'(4 * i);
         if (i > 0) fetch_instr = 32'hC000_0200 + 32'(4 * (i - 1));
         tick();
      end
      req_valid = 1'b0; fetch_instr = 'x; out_ready = 1'b1;
      #1;
      chk("s3_full_order", fetch_order, 1'b0);
      chk("s3_full_rdy", req_ready, 1'b0);
      chk("s3_full_outv", out_valid, 1'b1);
      chk("s3_full_opc", out_pc, 32'h200);
      chk("s3_full_oinstr", out_instr, 32'hC000_0200);
      chk("s3_full_fpc", fetch_pc, 32'h210);
      tick();
      out_ready = 1'b0; fetch_instr = 32'hC000_0210;
      #1;
      chk("s3_fifth_order", fetch_order, 1'b1);
      chk("s3_fifth_fpc", fetch_pc, 32'h210);
      chk("s3_head_after_pop", out_pc, 32'h204);
      tick();
      fetch_done = 1'b0; fetch_instr = 'x;
      #1;
      chk("s3_idle_full", fetch_order, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("s3_drain_outv", out_valid, 1'b1);
         chk("s3_drain_opc", out_pc, 32'h204 + 32'(4 * i));
         chk("s3_drain_oinstr", out_instr, 32'hC000_0204 + 32'(4 * i));
         tick();
      end
      out_ready = 1'b0;
      #1;
      chk("s3_empty", out_valid, 1'b0);
      stats_chk("s3", 32'd10, 32'd3);

      // back-to-back stream with continuous pops
      out_ready = 1'b1; fetch_done = 1'b1;
      for (int t = 0; t < 10; t++) begin
         req_valid = (t < 8);
         req_pc = 32'(4 * t);
         fetch_instr = (t >= 1) ? 32'hE000_0000 + 32'(4 * (t - 1)) : 'x;
         #1;
         if (t >= 2) begin
            chk("s4_outv", out_valid, 1'b1);
            chk("s4_opc", out_pc, 32'(4 * (t - 2)));
            chk("s4_oinstr", out_instr, 32'hE000_0000 + 32'(4 * (t - 2)));
         end
         chk("s4_order", fetch_order, (t >= 1) && (t <= 8));
         tick();
      end
      #1;
      chk("s4_empty", out_valid, 1'b0);
      out_ready = 1'b0; fetch_done = 1'b0; fetch_instr = 'x;
      stats_chk("s4", 32'd18, 32'd3);

      // flush while in MISS with two entries queued
      fetch_done = 1'b1; req_valid = 1'b1; req_pc = 32'h300;
      tick();
      req_pc = 32'h304; fetch_instr = 32'hD000_0300;
      tick();
      req_pc = 32'h308; fetch_instr = 32'hD000_0304;
      tick();
      req_valid = 1'b0; fetch_done = 1'b0; fetch_instr = 'x;
      tick();
      flush = 1'b1; req_valid = 1'b1; req_pc = 32'h400;
      fetch_done = 1'b1; fetch_instr = 32'hBAD0_0000;
      #1;
      chk("s5_pre_outv", out_valid, 1'b1);
      chk("s5_pre_opc", out_pc, 32'h300);
      chk("s5_pre_order", fetch_order, 1'b1);
      chk("s5_flush_rdy", req_ready, 1'b0);
      tick();
      flush = 1'b0; req_valid = 1'b0; fetch_done = 1'b0; fetch_instr = 'x;
      #1;
      chk("s5_outv", out_valid, 1'b0);
      chk("s5_idle", fetch_order, 1'b0);
      chk("s5_rdy", req_ready, 1'b1);
      chk("s5_not_accepted", fetch_pc, 32'h308);
      stats_chk("s5", 32'd22, 32'd4);

      // asynchronous reset while in MISS with one entry queued
      fetch_done = 1'b1; req_valid = 1'b1; req_pc = 32'h500;
      tick();
      req_pc = 32'h504; fetch_instr = 32'hF000_0500;
      tick();
      req_valid = 1'b0; fetch_done = 1'b0; fetch_instr = 'x;
      tick();
      #1;
      chk("s6_pre_outv", out_valid, 1'b1);
      chk("s6_pre_order", fetch_order, 1'b1);
      #2 rstn = 1'b0;
      #1;
      chk_reset_vals("s6_rst");
      stats_chk("s6_rst", 32'd0, 32'd0);
      #1 rstn = 1'b1;
      tick();

      req_valid = 1'b1; req_pc = 32'h600; fetch_done = 1'b1; fetch_instr = 32'h6060_6060;
      #1;
      chk("s6_req_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      #1;
      chk("s6_order", fetch_order, 1'b1);
      chk("s6_fpc", fetch_pc, 32'h600);
      chk("s6_outv_early", out_valid, 1'b0);
      tick();
      fetch_done = 1'b0; fetch_instr = 'x;
      #1;
      chk("s6_outv", out_valid, 1'b1);
      chk("s6_opc", out_pc, 32'h600);
      chk("s6_oinstr", out_instr, 32'h6060_6060);
      stats_chk("s6", 32'd1, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
